// File: rtl/display_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// display_pkg: shared scan states and segment/anode constants.
// Rev 1.0
// ----------------------------------------------------------------
package display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      BLANK = 2'd2
   } scan_state_e;

   localparam logic [6:0] SEG_OFF   = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [3:0] ANODE_OFF = 4'hF;

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ----------------------------------------------------------------
// bcd_to_seg7: BCD nibble to active-low {g,f,e,d,c,b,a}; 10-15 = dash.
// Rev 1.0
// ----------------------------------------------------------------
module bcd_to_seg7
   import display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = SEG_DASH;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------
// display_scan_ctrl: 4-digit multiplexed seven-segment scanner with
// inter-digit blanking and frame-synchronous double buffering. Rev 1.0
// ----------------------------------------------------------------
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int PRESC_W   = 10,
   parameter int BLANK_CYC = 8
) (
   input  logic        clk_ds,
   input  logic        rst_ds,
   input  logic        en_ds,
   input  logic        load_ds,
   input  logic [15:0] digits_ds,
   input  logic [3:0]  mask_ds,
   input  logic        lz_ds,
   output logic [6:0]  seg_ds,
   output logic [3:0]  an_ds,
   output logic [1:0]  idx_ds,
   output logic        frame_ds
);

   localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYC - 1);

   scan_state_e         state_q, state_d;
   logic [1:0]          idx_q, idx_d;
   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic [7:0]          blank_q, blank_d;
   logic                frame_q, frame_d;
   logic [6:0]          seg_q, seg_d;
   logic [3:0]          an_q, an_d;

   logic [15:0]         act_digits_q, act_digits_d;
   logic [3:0]          act_mask_q, act_mask_d;
   logic                act_lz_q, act_lz_d;
   logic [15:0]         pend_digits_q, pend_digits_d;
   logic [3:0]          pend_mask_q, pend_mask_d;
   logic                pend_lz_q, pend_lz_d;
   logic                pend_q, pend_d;

   logic                commit;
   logic [3:0]          nib;
   logic [6:0]          glyph;
   logic [3:0]          dark_vec;
   logic                z3, z2, z1;
   logic                lit;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      presc_d = presc_q;
      blank_d = blank_q;
      frame_d = 1'b0;
      if (!en_ds) begin
         state_d = IDLE;
         idx_d   = 2'd0;
         presc_d = '0;
         blank_d = 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = DRIVE;
               idx_d   = 2'd0;
               presc_d = '0;
               blank_d = 8'd0;
            end
            DRIVE: begin
               presc_d = presc_q + 1'b1;
               if (&presc_q) begin
                  state_d = BLANK;
                  idx_d   = idx_q + 2'd1;
                  blank_d = 8'd0;
                  frame_d = (idx_q == 2'd3);
               end
            end
            BLANK: begin
               if (blank_q == BLANK_LAST) begin
                  state_d = DRIVE;
                  presc_d = '0;
                  blank_d = 8'd0;
               end else begin
                  blank_d = blank_q + 8'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Commit only at the frame boundary so a frame never mixes two buffers.
   assign commit = frame_d || (state_q == IDLE);

   always_comb begin
      act_digits_d  = act_digits_q;
      act_mask_d    = act_mask_q;
      act_lz_d      = act_lz_q;
      pend_digits_d = pend_digits_q;
      pend_mask_d   = pend_mask_q;
      pend_lz_d     = pend_lz_q;
      pend_d        = pend_q;
      if (load_ds) begin
         pend_digits_d = digits_ds;
         pend_mask_d   = mask_ds;
         pend_lz_d     = lz_ds;
         pend_d        = 1'b1;
      end
      if (commit) begin
         if (load_ds) begin
            act_digits_d = digits_ds;
            act_mask_d   = mask_ds;
            act_lz_d     = lz_ds;
         end else if (pend_q) begin
            act_digits_d = pend_digits_q;
            act_mask_d   = pend_mask_q;
            act_lz_d     = pend_lz_q;
         end
         pend_d = 1'b0;
      end
   end

   always_comb begin
      nib = act_digits_d[3:0];
      case (idx_d)
         2'd0:    nib = act_digits_d[3:0];
         2'd1:    nib = act_digits_d[7:4];
         2'd2:    nib = act_digits_d[11:8];
         default: nib = act_digits_d[15:12];
      endcase
   end

   bcd_to_seg7 u_dec (
      .bcd (nib),
      .seg (glyph)
   );

   // Leading-zero run from digit 3 downward; digit 0 always shows.
   assign z3       = (act_digits_d[15:12] == 4'd0);
   assign z2       = z3 && (act_digits_d[11:8] == 4'd0);
   assign z1       = z2 && (act_digits_d[7:4] == 4'd0);
   assign dark_vec = act_mask_d | ({z3, z2, z1, 1'b0} & {4{act_lz_d}});
   assign lit      = (state_d == DRIVE) && !dark_vec[idx_d];

   always_comb begin
      seg_d = SEG_OFF;
      an_d  = ANODE_OFF;
      if (lit) begin
         seg_d = glyph;
         an_d  = ~(4'b0001 << idx_d);
      end
   end

   always_ff @(posedge clk_ds or negedge rst_ds) begin
      if (!rst_ds) begin
         state_q       <= IDLE;
         idx_q         <= 2'd0;
         presc_q       <= '0;
         blank_q       <= 8'd0;
         frame_q       <= 1'b0;
         seg_q         <= SEG_OFF;
         an_q          <= ANODE_OFF;
         act_digits_q  <= 16'd0;
         act_mask_q    <= 4'd0;
         act_lz_q      <= 1'b0;
         pend_digits_q <= 16'd0;
         pend_mask_q   <= 4'd0;
         pend_lz_q     <= 1'b0;
         pend_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         presc_q       <= presc_d;
         blank_q       <= blank_d;
         frame_q       <= frame_d;
         seg_q         <= seg_d;
         an_q          <= an_d;
         act_digits_q  <= act_digits_d;
         act_mask_q    <= act_mask_d;
         act_lz_q      <= act_lz_d;
         pend_digits_q <= pend_digits_d;
         pend_mask_q   <= pend_mask_d;
         pend_lz_q     <= pend_lz_d;
         pend_q        <= pend_d;
      end
   end

   assign seg_ds   = seg_q;
   assign an_ds    = an_q;
   assign idx_ds   = idx_q;
   assign frame_ds = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------
// tb_display_scan_ctrl: directed scan/buffer scenarios, PRESC_W=3,
// BLANK_CYC=2 (40-cycle frame). Rev 1.0
// ----------------------------------------------------------------
module tb_display_scan_ctrl;

   logic        clk_ds    = 1'b0;
   logic        rst_ds    = 1'b0;
   logic        en_ds     = 1'b0;
   logic        load_ds   = 1'b0;
   logic [15:0] digits_ds = 16'd0;
   logic [3:0]  mask_ds   = 4'd0;
   logic        lz_ds     = 1'b0;
   logic [6:0]  seg_ds;
   logic [3:0]  an_ds;
   logic [1:0]  idx_ds;
   logic        frame_ds;

   int n_cmp = 0;
   int n_bad = 0;

   // One {an, seg} entry per digit slot, in scan order.
   logic [10:0] exp_q[$];

   localparam logic [13:0] IDLE_VEC = {1'b0, 2'd0, 4'hF, 7'h7F};

   always #5 clk_ds = ~clk_ds;

   display_scan_ctrl #(
      .PRESC_W   (3),
      .BLANK_CYC (2)
   ) dut (
      .clk_ds    (clk_ds),
      .rst_ds    (rst_ds),
      .en_ds     (en_ds),
      .load_ds   (load_ds),
      .digits_ds (digits_ds),
      .mask_ds   (mask_ds),
      .lz_ds     (lz_ds),
      .seg_ds    (seg_ds),
      .an_ds     (an_ds),
      .idx_ds    (idx_ds),
      .frame_ds  (frame_ds)
   );

   task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   // Glyph 7'h7F marks a dark slot (anode off).
   task automatic push4(input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3);
      logic [6:0] s [4];
      s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
      for (int k = 0; k < 4; k++) begin
         if (s[k] == 7'h7F) exp_q.push_back({4'hF, 7'h7F});
         else               exp_q.push_back({~(4'b0001 << k), s[k]});
      end
   endtask

   // Checks one full 40-cycle frame starting at the first drive cycle of
   // digit 0; optionally applies up to two single-cycle loads.
   task automatic check_frame(input int la1, input logic [15:0] d1, input logic l1,
                              input int la2, input logic [15:0] d2, input logic l2);
      logic [10:0] slot;
      logic [13:0] want;
      slot = 11'h7FF;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk_ds);
         if (c < 38 && (c % 10) < 8) begin
            if ((c % 10) == 0) begin
               if (exp_q.size() == 0) begin
                  n_bad++;
                  $error("FAIL scoreboard: observed empty queue expected slot entry");
                  slot = 11'h7FF;
               end else begin
                  slot = exp_q.pop_front();
               end
            end
            want = {1'b0, 2'(c / 10), slot};
         end else begin
            want = {(c == 38), 2'(((c / 10) + 1) % 4), 4'hF, 7'h7F};
         end
         chk($sformatf("frame_c%0d", c), {frame_ds, idx_ds, an_ds, seg_ds}, want);
         if (c == la1) begin
            load_ds = 1'b1; digits_ds = d1; lz_ds = l1;
         end else if (c == la2) begin
            load_ds = 1'b1; digits_ds = d2; lz_ds = l2;
         end else begin
            load_ds = 1'b0;
         end
      end
      load_ds = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk_ds);
      chk("reset_outputs", {frame_ds, idx_ds, an_ds, seg_ds}, IDLE_VEC);
      chk("reset_pend", {13'd0, dut.pend_q}, 14'd0);
      rst_ds = 1'b1;

      // Load in IDLE commits directly
      @(negedge clk_ds);
      load_ds = 1'b1; digits_ds = 16'h1234; lz_ds = 1'b0;
      @(negedge clk_ds);
      load_ds = 1'b0;
      chk("idle_dark", {frame_ds, idx_ds, an_ds, seg_ds}, IDLE_VEC);
      en_ds = 1'b1;

      push4(7'h19, 7'h30, 7'h24, 7'h79);
      check_frame(-1, 16'h0, 1'b0, -1, 16'h0, 1'b0);
      push4(7'h19, 7'h30, 7'h24, 7'h79);
      check_frame(5, 16'h0012, 1'b1, -1, 16'h0, 1'b0);

      // Leading-zero suppression
      push4(7'h24, 7'h79, 7'h7F, 7'h7F);
      check_frame(5, 16'h0000, 1'b1, -1, 16'h0, 1'b0);
      push4(7'h40, 7'h7F, 7'h7F, 7'h7F);
      check_frame(10, 16'h1111, 1'b0, 35, 16'h2222, 1'b0);

      // Only the last pending value is displayed; load on boundary edge
      push4(7'h24, 7'h24, 7'h24, 7'h24);
      check_frame(37, 16'hABCD, 1'b0, -1, 16'h0, 1'b0);
      push4(7'h3F, 7'h3F, 7'h3F, 7'h3F);
      mask_ds = 4'b0101;
      check_frame(3, 16'h5678, 1'b0, -1, 16'h0, 1'b0);
      mask_ds = 4'b0000;
      push4(7'h7F, 7'h78, 7'h7F, 7'h12);
      check_frame(3, 16'h9876, 1'b0, -1, 16'h0, 1'b0);

      // Enable dropped during digit 2 drive
      for (int c = 0; c < 22; c++) @(negedge clk_ds);
      chk("drive_d2", {frame_ds, idx_ds, an_ds, seg_ds}, {1'b0, 2'd2, 4'b1011, 7'h00});
      en_ds = 1'b0;
      @(negedge clk_ds);
      chk("en_drop_idle", {frame_ds, idx_ds, an_ds, seg_ds}, IDLE_VEC);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_ds);
         chk($sformatf("idle_hold%0d", c), {frame_ds, idx_ds, an_ds, seg_ds}, IDLE_VEC);
      end
      en_ds = 1'b1;
      push4(7'h02, 7'h78, 7'h00, 7'h10);
      check_frame(-1, 16'h0, 1'b0, -1, 16'h0, 1'b0);

      // Asynchronous reset mid-drive
      @(negedge clk_ds);
      @(negedge clk_ds);
      load_ds = 1'b1; digits_ds = 16'h5555; lz_ds = 1'b0;
      @(negedge clk_ds);
      load_ds = 1'b0;
      chk("pend_set", {13'd0, dut.pend_q}, 14'd1);
      chk("pre_reset_d0", {frame_ds, idx_ds, an_ds, seg_ds}, {1'b0, 2'd0, 4'b1110, 7'h02});
      #2 rst_ds = 1'b0;
      #1;
      chk("async_reset_outputs", {frame_ds, idx_ds, an_ds, seg_ds}, IDLE_VEC);
      chk("async_reset_pend", {13'd0, dut.pend_q}, 14'd0);
      @(negedge clk_ds);
      rst_ds = 1'b1;
      push4(7'h40, 7'h40, 7'h40, 7'h40);
      check_frame(-1, 16'h0, 1'b0, -1, 16'h0, 1'b0);
      push4(7'h40, 7'h40, 7'h40, 7'h40);
      check_frame(-1, 16'h0, 1'b0, -1, 16'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
